// File: rtl/uart_seq_ctrl.sv
// uart_seq_ctrl: word-level sequencer between user logic and a byte uart_tx/uart_rx pair
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx_data      received byte from uart_rx
//   rx_valid     1-cycle pulse, rx_data valid
//   tx_done      1-cycle pulse, uart_tx finished its byte
//   start_tx     1-cycle pulse, uart_tx sends tx_data
//   tx_data      byte to uart_tx, held from start_tx until tx_done
//   tx_nums      vector to send, num k at [k*NUM_W +: NUM_W]
//   send_data    request to capture tx_nums and send it
//   tx_ready     idle, send_data accepted this cycle
//   rx_nums      last complete received vector, same packing as tx_nums
//   rx_available 1-cycle pulse, rx_nums just updated
//   rx_error     1-cycle pulse, partial vector dropped after idle timeout
module uart_seq_ctrl #(
   parameter int N_TX_NUMS  = 1,
   parameter int N_RX_NUMS  = 4,
   parameter int NUM_W      = 16,
   parameter int RX_TIMEOUT = 100000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 rx_data,
   input  logic                       rx_valid,
   input  logic                       tx_done,
   output logic                       start_tx,
   output logic [7:0]                 tx_data,
   input  logic [N_TX_NUMS*NUM_W-1:0] tx_nums,
   input  logic                       send_data,
   output logic                       tx_ready,
   output logic [N_RX_NUMS*NUM_W-1:0] rx_nums,
   output logic                       rx_available,
   output logic                       rx_error
);
   localparam int BPN   = NUM_W / 8;
   localparam int NB_TX = N_TX_NUMS * BPN;
   localparam int NB_RX = N_RX_NUMS * BPN;
   localparam int TXW   = N_TX_NUMS * NUM_W;
   localparam int RXW   = N_RX_NUMS * NUM_W;
   localparam int TIW   = NB_TX > 1 ? $clog2(NB_TX) : 1;
   localparam int RCW   = $clog2(NB_RX + 1);
   localparam int TW    = $clog2(RX_TIMEOUT + 1);

   // Bit offset of serial byte b inside a packed vector: num 0 first, MS byte first.
   function automatic int byte_pos(input int b);
      return (b / BPN) * NUM_W + NUM_W - 8 - 8 * (b % BPN);
   endfunction

   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_e;

   tx_state_e        state_q;
   logic [TXW-1:0]   shadow_q;
   logic [TIW-1:0]   idx_q;
   logic             start_tx_q;
   logic [7:0]       tx_data_q;
   logic             tx_ready_q;
   logic [TIW-1:0]   idx_nxt;
   logic [7:0]       nxt_byte;
   logic             last_byte;

   assign idx_nxt   = idx_q + 1'b1;
   assign nxt_byte  = shadow_q[byte_pos(int'(idx_nxt)) +: 8];
   assign last_byte = idx_q == TIW'(NB_TX - 1);

   // Outputs are registered: start_tx/tx_data are loaded on the edge that enters TX_SEND.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= TX_IDLE;
         shadow_q   <= '0;
         idx_q      <= '0;
         start_tx_q <= 1'b0;
         tx_data_q  <= '0;
         tx_ready_q <= 1'b1;
      end else begin
         start_tx_q <= 1'b0;
         case (state_q)
            TX_IDLE: if (send_data) begin
               shadow_q   <= tx_nums;
               idx_q      <= '0;
               tx_data_q  <= tx_nums[NUM_W-1 -: 8];
               start_tx_q <= 1'b1;
               tx_ready_q <= 1'b0;
               state_q    <= TX_SEND;
            end
            TX_SEND: state_q <= TX_WAIT;
            TX_WAIT: if (tx_done) begin
               if (last_byte) begin
                  tx_ready_q <= 1'b1;
                  state_q    <= TX_IDLE;
               end else begin
                  idx_q      <= idx_nxt;
                  tx_data_q  <= nxt_byte;
                  start_tx_q <= 1'b1;
                  state_q    <= TX_SEND;
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign start_tx = start_tx_q;
   assign tx_data  = tx_data_q;
   assign tx_ready = tx_ready_q;

   logic [RXW-1:0] buf_q, buf_d;
   logic [RXW-1:0] nums_q, nums_d;
   logic [RCW-1:0] cnt_q, cnt_d;
   logic [TW-1:0]  to_q, to_d, to_inc;
   logic           avail_q, avail_d;
   logic           err_q, err_d;

   // Bytes land directly at their final packed position, so completion is a plain copy.
   always_comb begin
      buf_d   = buf_q;
      nums_d  = nums_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      avail_d = 1'b0;
      err_d   = 1'b0;
      to_inc  = to_q == TW'(RX_TIMEOUT) ? to_q : to_q + 1'b1;
      if (rx_valid) begin
         buf_d[byte_pos(int'(cnt_q)) +: 8] = rx_data;
         to_d = '0;
         if (cnt_q == RCW'(NB_RX - 1)) begin
            nums_d  = buf_d;
            avail_d = 1'b1;
            cnt_d   = '0;
         end else
            cnt_d = cnt_q + 1'b1;
      end else if (cnt_q != '0) begin
         if (to_inc == TW'(RX_TIMEOUT)) begin
            cnt_d = '0;
            to_d  = '0;
            err_d = 1'b1;
         end else
            to_d = to_inc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q   <= '0;
         nums_q  <= '0;
         cnt_q   <= '0;
         to_q    <= '0;
         avail_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         nums_q  <= nums_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         avail_q <= avail_d;
         err_q   <= err_d;
      end
   end

   assign rx_nums      = nums_q;
   assign rx_available = avail_q;
   assign rx_error     = err_q;
endmodule
